sonic_cmd_exec: RTL and testbench

- Command executor directly downstream of the SoNIC command programming registers.
- Consumes the latched command (cmd_type, cmd_param0..2, cmd_base_rc, cmd_3dw_rcadd, init) on a cmd_go pulse and decodes the opcode.
- Applies port control or fetches a statistic.
- Returns a 2-DW completion record to the host response address through a req/ack handshake with the TX write arbiter.

---
 rtl/sonic_cmd_exec.sv | 179 +++++++++++++++++
 tb/tb_sonic_cmd_exec.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sonic_cmd_exec.sv
// SoNIC command executor: decodes a latched host command, applies port control or fetches a
// statistic, and returns a 2-DW completion record. Optional: SONIC_CMD_RESP_TIMEOUT_EN.
module sonic_cmd_exec #(
  parameter int unsigned NUM_PORTS    = 2,
  parameter int unsigned STAT_WAIT    = 64,
  parameter int unsigned RESP_TIMEOUT = 1024
) (
  input  logic                 clk_in,
  input  logic                 rstn,
  input  logic                 init,
  input  logic                 cmd_go,
  input  logic [31:0]          cmd_type,
  input  logic [31:0]          cmd_param0,
  input  logic [31:0]          cmd_param1,
  input  logic [31:0]          cmd_param2,
  input  logic [63:0]          cmd_base_rc,
  input  logic                 cmd_3dw_rcadd,
  output logic [NUM_PORTS-1:0] port_en,
  output logic [31:0]          idle_gap,
  output logic [7:0]           stat_sel,
  output logic                 stat_req,
  input  logic                 stat_valid,
  input  logic [31:0]          stat_data,
  output logic                 resp_req,
  input  logic                 resp_ack,
  output logic [63:0]          resp_addr,
  output logic                 resp_3dw,
  output logic [63:0]          resp_data,
  output logic                 busy,
  output logic [15:0]          drop_cnt,
  output logic                 resp_timeout
);

  localparam logic [7:0] OP_PORT_START = 8'h01;
  localparam logic [7:0] OP_PORT_STOP  = 8'h02;
  localparam logic [7:0] OP_SET_IDLE   = 8'h03;
  localparam logic [7:0] OP_READ_STAT  = 8'h04;

  localparam logic [7:0] ST_OK           = 8'h00;
  localparam logic [7:0] ST_BAD_OPCODE   = 8'h01;
  localparam logic [7:0] ST_BAD_PARAM    = 8'h02;
  localparam logic [7:0] ST_STAT_TIMEOUT = 8'h03;

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_STAT, S_RESP} state_t;

  state_t      state, state_nx;
  logic [7:0]  cap_op;
  logic [15:0] cap_tag;
  logic [31:0] cap_p0;
  logic [63:0] cap_base;
  logic        cap_3dw;
  logic [31:0] result;
  logic [7:0]  status;
  logic [31:0] stat_cnt;
  logic [31:0] mask_hi;
  logic        accept, bad_mask, stat_expire, resp_done;
  logic        unused_inputs;

  assign unused_inputs = ^{cmd_type[15:8], cmd_param1, cmd_param2};

  assign accept      = cmd_go && !init && (state == S_IDLE);
  assign mask_hi     = cap_p0 >> NUM_PORTS;
  assign bad_mask    = (cap_p0 == '0) || (mask_hi != '0);
  assign stat_expire = (stat_cnt == 32'(STAT_WAIT - 1));

  assign busy      = (state != S_IDLE);
  assign stat_req  = (state == S_STAT) && !init;
  assign resp_req  = (state == S_RESP) && (cap_base != '0) && !init;
  assign resp_addr = cap_base;
  assign resp_3dw  = cap_3dw;
  assign resp_data = {result, cap_tag, status, cap_op};

`ifdef SONIC_CMD_RESP_TIMEOUT_EN
  logic [31:0] rsp_cnt;
  logic        rsp_expire;

  assign rsp_expire = resp_req && !resp_ack && (rsp_cnt == 32'(RESP_TIMEOUT - 1));
  assign resp_done  = (cap_base == '0) || (resp_req && resp_ack) || rsp_expire;

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      rsp_cnt      <= '0;
      resp_timeout <= 1'b0;
    end else begin
      rsp_cnt <= resp_req ? rsp_cnt + 32'd1 : '0;
      if (rsp_expire) resp_timeout <= 1'b1;
    end
  end
`else
  assign resp_done    = (cap_base == '0) || (resp_req && resp_ack);
  assign resp_timeout = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (accept) state_nx = S_DECODE;
      S_DECODE: state_nx = (cap_op == OP_READ_STAT) ? S_STAT : S_RESP;
      S_STAT:   if (stat_valid || stat_expire) state_nx = S_RESP;
      S_RESP:   if (resp_done) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
    if (init) state_nx = S_IDLE;
  end

  // drop_cnt keeps counting through init; only rstn clears it
  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) drop_cnt <= '0;
    else if (cmd_go && (init || state != S_IDLE) && drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
  end

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      cap_op   <= '0;
      cap_tag  <= '0;
      cap_p0   <= '0;
      cap_base <= '0;
      cap_3dw  <= 1'b0;
      result   <= '0;
      status   <= '0;
      stat_cnt <= '0;
      port_en  <= '0;
      idle_gap <= '0;
      stat_sel <= '0;
    end else if (init) begin
      port_en  <= '0;
      idle_gap <= '0;
      stat_cnt <= '0;
    end else begin
      if (accept) begin
        cap_op   <= cmd_type[7:0];
        cap_tag  <= cmd_type[31:16];
        cap_p0   <= cmd_param0;
        cap_base <= cmd_base_rc;
        cap_3dw  <= cmd_3dw_rcadd;
      end
      case (state)
        S_DECODE: begin
          result   <= cap_p0;
          status   <= ST_OK;
          stat_cnt <= '0;
          case (cap_op)
            OP_PORT_START: begin
              if (bad_mask) status <= ST_BAD_PARAM;
              else          port_en <= port_en | cap_p0[NUM_PORTS-1:0];
            end
            OP_PORT_STOP: begin
              if (bad_mask) status <= ST_BAD_PARAM;
              else          port_en <= port_en & ~cap_p0[NUM_PORTS-1:0];
            end
            OP_SET_IDLE: begin
              if (cap_p0 == '0) status <= ST_BAD_PARAM;
              else              idle_gap <= cap_p0;
            end
            OP_READ_STAT: stat_sel <= cap_p0[7:0];
            default:      status <= ST_BAD_OPCODE;
          endcase
        end
        S_STAT: begin
          stat_cnt <= stat_cnt + 32'd1;
          if (stat_valid) begin
            result <= stat_data;
            status <= ST_OK;
          end else if (stat_expire) begin
            result <= '0;
            status <= ST_STAT_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sonic_cmd_exec.sv
// Randomized scoreboard bench for sonic_cmd_exec with an opcode-level reference model.
module tb_sonic_cmd_exec;
  localparam int NP = 2;
  localparam int SW = 64;
  localparam int RT = 1024;

  logic          clk_in = 1'b0;
  logic          rstn, init, cmd_go;
  logic [31:0]   cmd_type, cmd_param0, cmd_param1, cmd_param2;
  logic [63:0]   cmd_base_rc;
  logic          cmd_3dw_rcadd;
  logic [NP-1:0] port_en;
  logic [31:0]   idle_gap;
  logic [7:0]    stat_sel;
  logic          stat_req, stat_valid;
  logic [31:0]   stat_data;
  logic          resp_req, resp_ack;
  logic [63:0]   resp_addr, resp_data;
  logic          resp_3dw, busy, resp_timeout;
  logic [15:0]   drop_cnt;

  sonic_cmd_exec #(.NUM_PORTS(NP), .STAT_WAIT(SW), .RESP_TIMEOUT(RT)) dut (
    .clk_in(clk_in), .rstn(rstn), .init(init), .cmd_go(cmd_go),
    .cmd_type(cmd_type), .cmd_param0(cmd_param0), .cmd_param1(cmd_param1),
    .cmd_param2(cmd_param2), .cmd_base_rc(cmd_base_rc), .cmd_3dw_rcadd(cmd_3dw_rcadd),
    .port_en(port_en), .idle_gap(idle_gap), .stat_sel(stat_sel), .stat_req(stat_req),
    .stat_valid(stat_valid), .stat_data(stat_data), .resp_req(resp_req), .resp_ack(resp_ack),
    .resp_addr(resp_addr), .resp_3dw(resp_3dw), .resp_data(resp_data), .busy(busy),
    .drop_cnt(drop_cnt), .resp_timeout(resp_timeout)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [63:0] addr;
    logic        dw3;
    logic [63:0] data;
  } resp_t;

  resp_t         sb[$];
  int unsigned   n_pass = 0;
  int unsigned   n_total = 0;
  logic [NP-1:0] m_port_en;
  logic [31:0]   m_idle;
  logic [7:0]    m_sel;
  logic [15:0]   m_drop;
  bit            ack_auto = 1'b0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  always @(negedge clk_in) begin
    if (rstn === 1'b1 && resp_req === 1'b1 && resp_ack === 1'b1) begin
      check("resp_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        resp_t e;
        e = sb.pop_front();
        check("resp_addr", resp_addr, e.addr);
        check("resp_3dw", 64'(resp_3dw), 64'(e.dw3));
        check("resp_data", resp_data, e.data);
      end
    end
  end

  initial begin
    resp_ack = 1'b0;
    forever begin
      @(posedge clk_in); #1;
      resp_ack = ack_auto ? ($urandom_range(0, 2) == 0) : 1'b0;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_in); #1;
  endtask

  task automatic model_reset();
    m_port_en = '0; m_idle = '0; m_sel = '0; m_drop = '0;
    sb.delete();
  endtask

  // stat_k: cycles after stat_req is first seen before stat_valid is pulsed; -1 means never
  task automatic issue(input logic [7:0] op, input logic [15:0] tag, input logic [31:0] p0,
                       input logic [63:0] base, input logic dw3, input int stat_k,
                       input logic [31:0] sdata);
    logic [7:0]  st;
    logic [31:0] res;
    st = 8'h00;
    res = p0;
    case (op)
      8'h01: if (p0 == 0 || p0 >= (1 << NP)) st = 8'h02; else m_port_en = m_port_en | p0[NP-1:0];
      8'h02: if (p0 == 0 || p0 >= (1 << NP)) st = 8'h02; else m_port_en = m_port_en & ~p0[NP-1:0];
      8'h03: if (p0 == 0) st = 8'h02; else m_idle = p0;
      8'h04: begin
        m_sel = p0[7:0];
        if (stat_k >= 0 && stat_k < SW) res = sdata;
        else begin st = 8'h03; res = 0; end
      end
      default: st = 8'h01;
    endcase
    if (base != 0) sb.push_back('{base, dw3, {res, tag, st, op}});
    cmd_type = {tag, 8'($urandom), op};
    cmd_param0 = p0;
    cmd_param1 = $urandom;
    cmd_param2 = $urandom;
    cmd_base_rc = base;
    cmd_3dw_rcadd = dw3;
    cmd_go = 1'b1;
    tick();
    cmd_go = 1'b0;
    cmd_type = $urandom; cmd_param0 = $urandom; cmd_base_rc = {$urandom, $urandom};
    cmd_3dw_rcadd = 1'($urandom);
  endtask

  task automatic wait_stat_req();
    int t = 0;
    while (stat_req !== 1'b1 && t < 10) begin tick(); t++; end
    check("stat_req_seen", 64'(stat_req), 64'd1);
  endtask

  task automatic feed_stat(input int k, input logic [31:0] sdata);
    wait_stat_req();
    if (k >= 0) begin
      repeat (k) tick();
      stat_valid = 1'b1;
      stat_data = sdata;
      tick();
      stat_valid = 1'b0;
      stat_data = $urandom;
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy !== 1'b0 && t < 3000) begin tick(); t++; end
    check("busy_clear", 64'(busy), 64'd0);
    check("sb_drained", 64'(sb.size()), 64'd0);
    check("port_en", 64'(port_en), 64'(m_port_en));
    check("idle_gap", 64'(idle_gap), 64'(m_idle));
    check("stat_sel", 64'(stat_sel), 64'(m_sel));
  endtask

  task automatic check_zero(string tag);
    check({tag, "_port_en"}, 64'(port_en), 64'd0);
    check({tag, "_idle_gap"}, 64'(idle_gap), 64'd0);
    check({tag, "_stat_sel"}, 64'(stat_sel), 64'd0);
    check({tag, "_stat_req"}, 64'(stat_req), 64'd0);
    check({tag, "_resp_req"}, 64'(resp_req), 64'd0);
    check({tag, "_resp_addr"}, resp_addr, 64'd0);
    check({tag, "_resp_3dw"}, 64'(resp_3dw), 64'd0);
    check({tag, "_resp_data"}, resp_data, 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_drop_cnt"}, 64'(drop_cnt), 64'd0);
    check({tag, "_resp_timeout"}, 64'(resp_timeout), 64'd0);
  endtask

  initial begin
    rstn = 1'b0; init = 1'b0; cmd_go = 1'b0;
    cmd_type = '0; cmd_param0 = '0; cmd_param1 = '0; cmd_param2 = '0;
    cmd_base_rc = '0; cmd_3dw_rcadd = 1'b0; stat_valid = 1'b0; stat_data = '0;
    model_reset();
    repeat (3) tick();
    check_zero("reset");
    rstn = 1'b1;
    ack_auto = 1'b1;
    tick();

    // PORT_START with cycle-exact latency
    issue(8'h01, 16'h0005, 32'h3, 64'h0000_0000_1000_0040, 1'b1, -1, 0);
    tick();
    check("start_port_en_n2", 64'(port_en), 64'h3);
    check("start_resp_req_n2", 64'(resp_req), 64'd1);
    check("start_resp_data", resp_data, 64'h0000_0003_0005_0001);
    check("start_resp_3dw", 64'(resp_3dw), 64'd1);
    wait_idle();

    issue(8'h04, 16'h0009, 32'h07, 64'h0000_0002_0000_0100, 1'b0, 5, 32'hDEADBEEF);
    feed_stat(5, 32'hDEADBEEF);
    wait_idle();
    issue(8'h04, 16'h000A, 32'h07, 64'h0000_0002_0000_0200, 1'b0, -1, 0);
    feed_stat(-1, 0);
    wait_idle();
    issue(8'h04, 16'h000B, 32'h12, 64'h0000_0000_0000_0300, 1'b1, SW - 1, 32'h1234_5678);
    feed_stat(SW - 1, 32'h1234_5678);
    wait_idle();
    issue(8'h04, 16'h000C, 32'h13, 64'h0000_0000_0000_0400, 1'b1, SW, 32'h8765_4321);
    feed_stat(SW, 32'h8765_4321);
    wait_idle();

    issue(8'h7F, 16'h0011, 32'h1, 64'h0000_0000_0000_0500, 1'b1, -1, 0);
    wait_idle();
    issue(8'h02, 16'h0012, 32'h4, 64'h0000_0000_0000_0600, 1'b1, -1, 0);
    wait_idle();
    issue(8'h03, 16'h0013, 32'h0, 64'h0000_0000_0000_0700, 1'b1, -1, 0);
    wait_idle();
    issue(8'h03, 16'h0014, 32'h60, 64'h0, 1'b1, -1, 0);
    wait_idle();

    // cmd_go during STAT is dropped; cmd_go under init is dropped and init clears port state
    issue(8'h04, 16'h0021, 32'h05, 64'h0000_0000_0000_0800, 1'b1, -1, 0);
    wait_stat_req();
    repeat (3) tick();
    cmd_type = 32'h0022_0002; cmd_param0 = 32'h3; cmd_base_rc = 64'h900;
    cmd_go = 1'b1;
    tick();
    cmd_go = 1'b0;
    m_drop++;
    wait_idle();
    check("drop_during_stat", 64'(drop_cnt), 64'(m_drop));
    init = 1'b1; cmd_go = 1'b1; cmd_type = 32'h0023_0001; cmd_param0 = 32'h1;
    tick();
    init = 1'b0; cmd_go = 1'b0;
    m_drop++; m_port_en = '0; m_idle = '0;
    tick();
    check("drop_in_init", 64'(drop_cnt), 64'(m_drop));
    check("init_busy", 64'(busy), 64'd0);
    check("init_port_en", 64'(port_en), 64'd0);
    check("init_idle_gap", 64'(idle_gap), 64'd0);

    for (int n = 0; n < 40; n++) begin
      logic [7:0]  op;
      logic [31:0] p0;
      logic [63:0] base;
      int          k;
      int          r;
      r = $urandom_range(0, 9);
      if (r <= 2)      op = 8'h01;
      else if (r <= 4) op = 8'h02;
      else if (r == 5) op = 8'h03;
      else if (r <= 7) op = 8'h04;
      else             op = 8'($urandom_range(5, 255));
      if (op == 8'h01 || op == 8'h02) p0 = $urandom_range(0, 7);
      else if (op == 8'h03)           p0 = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      else                            p0 = $urandom;
      base = ($urandom_range(0, 4) == 0) ? 64'h0 : {$urandom, $urandom};
      k = ($urandom_range(0, 4) == 0) ? -1 : $urandom_range(0, 70);
      issue(op, 16'($urandom), p0, base, 1'($urandom), k, $urandom);
      if (op == 8'h04) feed_stat(k, sb.size() != 0 ? sb[sb.size() - 1].data[63:32] : $urandom);
      wait_idle();
    end

`ifdef SONIC_CMD_RESP_TIMEOUT_EN
    begin
      int t;
      ack_auto = 1'b0;
      repeat (2) tick();
      issue(8'h03, 16'h0031, 32'h44, 64'h0000_0000_0000_0A00, 1'b1, -1, 0);
      t = 0;
      while (resp_req !== 1'b1 && t < 5) begin tick(); t++; end
      t = 0;
      while (resp_req === 1'b1 && t < RT + 100) begin t++; tick(); end
      check("resp_wait_cycles", 64'(t), 64'(RT));
      check("resp_timeout_set", 64'(resp_timeout), 64'd1);
      check("resp_req_dropped", 64'(resp_req), 64'd0);
      sb.delete();
      wait_idle();
      ack_auto = 1'b1;
    end
`else
    check("resp_timeout_tied", 64'(resp_timeout), 64'd0);
`endif

    // reset while a response is pending
    ack_auto = 1'b0;
    repeat (2) tick();
    issue(8'h03, 16'h0041, 32'h99, 64'h0000_0000_0000_0B00, 1'b1, -1, 0);
    tick();
    check("pre_reset_resp_req", 64'(resp_req), 64'd1);
    rstn = 1'b0;
    #2;
    check_zero("midreset");
    model_reset();
    tick();
    rstn = 1'b1;
    ack_auto = 1'b1;
    tick();
    issue(8'h01, 16'h0042, 32'h2, 64'h0000_0000_0000_0C00, 1'b0, -1, 0);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
